// File: rtl/llr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : llr_pkg
//  Description : Shared definitions for the LLR loader: lane geometry,
//                frame length-code encoding, FSM state encoding and a helper
//                that maps a length code to the index of the frame's last LLR.
//  Revision    : 1.0 - initial release
// ============================================================================
package llr_pkg;

    // One sign-magnitude LLR and the number of LLRs packed per memory word.
    localparam int LLR_W = 8;
    localparam int PACK  = 8;

    // Accepted-LLR counter width; covers the longest frame (1024 LLRs).
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        LEN_128  = 2'b00,
        LEN_256  = 2'b01,
        LEN_512  = 2'b10,
        LEN_1024 = 2'b11
    } len_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Index of the final LLR of a frame (N-1), compared against the running
    // count so the counter never advances past the frame length.
    function automatic logic [CNT_W-1:0] last_index(input len_code_e code);
        logic [CNT_W-1:0] idx;
        case (code)
            LEN_128:  idx = 10'd127;
            LEN_256:  idx = 10'd255;
            LEN_512:  idx = 10'd511;
            LEN_1024: idx = 10'd1023;
            default:  idx = 10'd1023;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : llr_loader
//  Description : Accepts a frame of sign-magnitude LLRs one per transfer and
//                packs PACK of them into a word for the downstream LLR memory.
//                Lane j of a word holds the j-th LLR of that word in frame
//                order; bits pass through untouched.
//  Ports       : i_clk      - clock, rising edge
//                i_rst_n    - synchronous active-low reset
//                i_start    - frame start pulse (sampled only in IDLE)
//                i_len      - length code 00/01/10/11 = 128/256/512/1024 LLRs
//                i_valid    - i_llr carries a valid LLR
//                i_llr      - sign-magnitude LLR
//                o_ready    - loader accepts i_llr this cycle (LOAD only)
//                o_wen      - one-cycle write strobe for o_data
//                o_data     - packed word, LLR k at bits [8k+7:8k]
//                o_word_cnt - words emitted in the current frame
//                o_busy     - high in LOAD and FLUSH
//                o_done     - one-cycle pulse with the final word's o_wen
//  Revision    : 1.0 - initial release
// ============================================================================
module llr_loader #(
    parameter int LLR_W = llr_pkg::LLR_W,
    parameter int PACK  = llr_pkg::PACK
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_len,
    input  logic                   i_valid,
    input  logic [LLR_W-1:0]       i_llr,
    output logic                   o_ready,
    output logic                   o_wen,
    output logic [LLR_W*PACK-1:0]  o_data,
    output logic [7:0]             o_word_cnt,
    output logic                   o_busy,
    output logic                   o_done
);

    import llr_pkg::*;

    localparam int                WORD_W    = LLR_W * PACK;
    localparam int                LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);

    state_e             state_q;
    logic               ready_q;
    logic               wen_q;
    logic               done_q;
    logic               busy_q;
    logic [WORD_W-1:0]  acc_q;
    logic [WORD_W-1:0]  data_q;
    logic [7:0]         word_cnt_q;
    logic [LANE_W-1:0]  lane_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_q;

    logic               accept;
    logic [WORD_W-1:0]  word_d;

    assign accept = i_valid & ready_q;

    // Partial word with the incoming LLR dropped into the current lane. When
    // the last lane is being accepted this is the complete word, which lets
    // the output register load it directly and the next word start at lane 0
    // in the following cycle without a bubble.
    always_comb begin
        word_d = acc_q;
        word_d[lane_q*LLR_W +: LLR_W] = i_llr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            acc_q      <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The LLR bus is ignored here even if i_valid is high;
                    // ready only rises once LOAD is entered.
                    if (i_start) begin
                        last_q     <= last_index(len_code_e'(i_len));
                        word_cnt_q <= '0;
                        cnt_q      <= '0;
                        lane_q     <= '0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        acc_q <= word_d;
                        if (lane_q == LANE_LAST) begin
                            lane_q     <= '0;
                            data_q     <= word_d;
                            wen_q      <= 1'b1;
                            word_cnt_q <= word_cnt_q + 8'd1;
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                        end
                        // Frame lengths are whole words, so the final LLR is
                        // always in the last lane and coincides with a write.
                        if (cnt_q == last_q) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= ST_FLUSH;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_wen      = wen_q;
    assign o_data     = data_q;
    assign o_word_cnt = word_cnt_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule
`default_nettype wire
